// File: rtl/vote_pipe_if.sv
// Handshake bundle for vote_pipe: input word set on one side, voted result on the other.
// The master drives words and consumes results; the slave is the voter.
interface vote_pipe_if #(
  parameter int N = 3,
  parameter int W = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_unanimous;
  logic [N-1:0]   out_dissent;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, out_unanimous, out_dissent
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, out_unanimous, out_dissent
  );
endinterface

// File: rtl/vote_pipe.sv
// Registered N-channel bitwise majority/minority voter with one output register
// and a saturating disagreement counter per channel.
module vote_pipe #(
  parameter int N     = 3,
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  vote_pipe_if.slave         vif,
  input  logic               clr_cnt,
  output logic [N*CNT_W-1:0] dis_cnt
);

  if ((N % 2) == 0 || N < 3) begin : g_bad_n
    $error("vote_pipe: N must be odd and >= 3");
  end

  function automatic logic [N-1:0] column(input logic [N*W-1:0] d, input int b);
    logic [N-1:0] col;
    col = '0;
    for (int k = 0; k < N; k++) col[k] = d[k*W + b];
    return col;
  endfunction

  function automatic logic maj_bit(input logic [N-1:0] bits);
    int pop;
    pop = 0;
    for (int k = 0; k < N; k++) pop += int'(bits[k]);
    return pop > (N / 2);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  logic           w_in_xfer;
  logic [N*W-1:0] w_data;
  logic [W-1:0]   w_maj;
  logic [N-1:0]   w_dissent;

  logic           r_vld_p1;
  logic [W-1:0]   r_data_p1;
  logic           r_unan_p1;
  logic [N-1:0]   r_dissent_p1;
  logic [CNT_W-1:0] r_cnt [N];

  // Masking keeps an undriven in_data from reaching the vote when nothing is offered.
  assign w_data    = vif.in_valid ? vif.in_data : '0;
  assign w_in_xfer = vif.in_valid && vif.in_ready;

  always_comb begin
    w_maj = '0;
    for (int b = 0; b < W; b++) w_maj[b] = maj_bit(column(w_data, b));
  end

  always_comb begin
    w_dissent = '0;
    for (int k = 0; k < N; k++) w_dissent[k] = (w_data[k*W +: W] != w_maj);
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_data_p1    <= '0;
      r_unan_p1    <= 1'b0;
      r_dissent_p1 <= '0;
    end else if (w_in_xfer) begin
      r_vld_p1     <= 1'b1;
      r_data_p1    <= vif.mode ? ~w_maj : w_maj;
      r_unan_p1    <= ~|w_dissent;
      r_dissent_p1 <= w_dissent;
    end else if (vif.out_ready) begin
      r_vld_p1     <= 1'b0;
    end
  end

  // Clear beats a simultaneous transfer: that transfer is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      for (int k = 0; k < N; k++) r_cnt[k] <= '0;
    end else if (w_in_xfer) begin
      for (int k = 0; k < N; k++) r_cnt[k] <= sat_inc(r_cnt[k], w_dissent[k]);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign dis_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign vif.in_ready      = !r_vld_p1 || vif.out_ready;
  assign vif.out_valid     = r_vld_p1;
  assign vif.out_data      = r_data_p1;
  assign vif.out_unanimous = r_unan_p1;
  assign vif.out_dissent   = r_dissent_p1;

endmodule

// File: tb/tb_vote_pipe.sv
// Scoreboard bench for vote_pipe: a 3x8 instance with 8-bit counters and a 5x16
// instance with 2-bit counters, both checked against an independent voting model.
module tb_vote_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic [4:0]  dis;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, clr_a, clr_b;
  logic [23:0] cnt_a;
  logic [9:0]  cnt_b;

  vote_pipe_if #(.N(3), .W(8))  ifa ();
  vote_pipe_if #(.N(5), .W(16)) ifb ();

  vote_pipe #(.N(3), .W(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_a), .vif(ifa.slave), .clr_cnt(clr_a), .dis_cnt(cnt_a)
  );
  vote_pipe #(.N(5), .W(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .vif(ifb.slave), .clr_cnt(clr_b), .dis_cnt(cnt_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   ea[3];
  int   eb[5];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int n, input int w, input logic [79:0] d, input logic m);
    exp_t e;
    logic [15:0] maj, wmask;
    int pop;
    logic a0, a1, a2;
    maj   = '0;
    wmask = 16'((32'd1 << w) - 1);
    for (int b = 0; b < w; b++) begin
      if (n == 3) begin
        a0 = d[b]; a1 = d[w+b]; a2 = d[2*w+b];
        maj[b] = a0 ? (a1 | a2) : (a1 & a2);
      end else begin
        pop = 0;
        for (int k = 0; k < n; k++) pop += int'(d[k*w+b]);
        maj[b] = (pop > n / 2);
      end
    end
    e.dis = '0;
    for (int k = 0; k < n; k++) e.dis[k] = ((16'(d >> (k*w)) & wmask) != maj);
    e.d = m ? (~maj & wmask) : maj;
    e.u = (e.dis == 5'd0);
    return e;
  endfunction

  task automatic cyc_a(input logic rst, input logic v, input logic [23:0] d,
                       input logic m, input logic ordy, input logic clr);
    exp_t e;
    logic rdy_m;
    @(negedge clk);
    rst_a = rst; ifa.in_valid = v; ifa.in_data = d; ifa.mode = m;
    ifa.out_ready = ordy; clr_a = clr;
    #1;
    rdy_m = (qa.size() == 0) || ordy;
    chk("a_vld", ifa.out_valid, qa.size() != 0);
    chk("a_rdy", ifa.in_ready, rdy_m);
    for (int k = 0; k < 3; k++) chk("a_cnt", 64'(cnt_a[k*8 +: 8]), 64'(ea[k]));
    if (qa.size() != 0) begin
      e = qa[0];
      chk("a_data", ifa.out_data, e.d[7:0]);
      chk("a_unan", ifa.out_unanimous, e.u);
      chk("a_dis", ifa.out_dissent, e.dis[2:0]);
      if (ordy && rst) void'(qa.pop_front());
    end
    if (!rst) begin
      qa.delete();
      for (int k = 0; k < 3; k++) ea[k] = 0;
    end else if (v && rdy_m) begin
      e = model(3, 8, {56'd0, d}, m);
      qa.push_back(e);
      for (int k = 0; k < 3; k++)
        ea[k] = clr ? 0 : ((ea[k] + int'(e.dis[k]) > 255) ? 255 : ea[k] + int'(e.dis[k]));
    end else if (clr) begin
      for (int k = 0; k < 3; k++) ea[k] = 0;
    end
  endtask

  task automatic cyc_b(input logic rst, input logic v, input logic [79:0] d,
                       input logic m, input logic ordy, input logic clr);
    exp_t e;
    logic rdy_m;
    @(negedge clk);
    rst_b = rst; ifb.in_valid = v; ifb.in_data = d; ifb.mode = m;
    ifb.out_ready = ordy; clr_b = clr;
    #1;
    rdy_m = (qb.size() == 0) || ordy;
    chk("b_vld", ifb.out_valid, qb.size() != 0);
    chk("b_rdy", ifb.in_ready, rdy_m);
    for (int k = 0; k < 5; k++) chk("b_cnt", 64'(cnt_b[k*2 +: 2]), 64'(eb[k]));
    if (qb.size() != 0) begin
      e = qb[0];
      chk("b_data", ifb.out_data, e.d);
      chk("b_unan", ifb.out_unanimous, e.u);
      chk("b_dis", ifb.out_dissent, e.dis);
      if (ordy && rst) void'(qb.pop_front());
    end
    if (!rst) begin
      qb.delete();
      for (int k = 0; k < 5; k++) eb[k] = 0;
    end else if (v && rdy_m) begin
      e = model(5, 16, d, m);
      qb.push_back(e);
      for (int k = 0; k < 5; k++)
        eb[k] = clr ? 0 : ((eb[k] + int'(e.dis[k]) > 3) ? 3 : eb[k] + int'(e.dis[k]));
    end else if (clr) begin
      for (int k = 0; k < 5; k++) eb[k] = 0;
    end
  endtask

  initial begin
    logic [23:0] da;
    logic [95:0] rb;
    int pat;

    rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.mode = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.mode = 1'b0; ifb.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) ea[i] = 0;
    for (int i = 0; i < 5; i++) eb[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", ifa.out_valid, 0);
    chk("rst_data", ifa.out_data, 0);
    chk("rst_unan", ifa.out_unanimous, 0);
    chk("rst_dis", ifa.out_dissent, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_rdy", ifa.in_ready, 1);

    // Every bit sees every channel pattern, in both modes, back to back.
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < 8; p++) begin
        da = '0;
        for (int k = 0; k < 3; k++)
          for (int b = 0; b < 8; b++) begin
            pat = (p + b) % 8;
            da[k*8 + b] = pat[k];
          end
        cyc_a(1, 1, da, m[0], 1, 0);
      end
    end

    cyc_a(1, 0, 24'd0, 0, 1, 1);
    cyc_a(1, 1, {8'hFF, 8'h5A, 8'h5A}, 0, 1, 0);
    chk("t2_data_pending", qa.size(), 1);
    cyc_a(1, 1, {3{8'h3C}}, 0, 1, 0);
    cyc_a(1, 0, 'x, 1, 1, 0);
    cyc_a(1, 0, 'x, 0, 1, 0);
    chk("t2_cnt2", cnt_a[23:16], 8'd1);
    chk("t2_cnt0", cnt_a[7:0], 8'd0);

    // Backpressure with a word waiting at the input.
    cyc_a(1, 1, 24'h123456, 0, 0, 0);
    repeat (4) cyc_a(1, 1, 24'hABCDEF, 1, 0, 0);
    cyc_a(1, 1, 24'hABCDEF, 1, 1, 0);
    for (int i = 0; i < 100; i++)
      cyc_a(1, $urandom_range(0, 3) != 0, 24'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    cyc_a(1, 1, {8'h00, 8'h01, 8'h00}, 0, 0, 0);
    cyc_a(1, 0, 24'd0, 0, 0, 0);
    cyc_a(0, 1, 24'hFF00FF, 0, 0, 0);
    cyc_a(1, 0, 24'd0, 0, 0, 0);
    chk("t5_cnt", cnt_a, 0);
    chk("t5_data", ifa.out_data, 0);
    for (int i = 0; i < 10 && qa.size() != 0; i++) cyc_a(1, 0, 24'd0, 0, 1, 0);
    chk("a_drain", qa.size(), 0);

    cyc_b(0, 0, 80'd0, 0, 0, 0);
    cyc_b(1, 0, 80'd0, 0, 1, 0);
    chk("b_rst_data", ifb.out_data, 0);
    repeat (5) cyc_b(1, 1, {16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0}, 0, 1, 0);
    cyc_b(1, 0, 80'd0, 0, 1, 0);
    chk("t4_sat", cnt_b[3:2], 2'd3);
    cyc_b(1, 1, {16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0}, 0, 1, 1);
    cyc_b(1, 0, 80'd0, 0, 1, 0);
    chk("t4_clr", cnt_b[3:2], 2'd0);
    for (int i = 0; i < 300; i++) begin
      rb = {$urandom, $urandom, $urandom};
      cyc_b(1, $urandom_range(0, 3) != 0, rb[79:0], 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 10 && qb.size() != 0; i++) cyc_b(1, 0, 80'd0, 0, 1, 0);
    chk("b_drain", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
